rc4_decrypt_core: RTL and testbench

Parametrised ARC4 decryption engine: runs the full S-box initialisation, key-scheduling shuffle and keystream/XOR phase for one key under a start/done handshake. It sits between the key source (switches today, key-search controller next) and three on-chip memories: S working RAM, encrypted-message ROM and decrypted-message RAM. It adds an optional plaintext validity check that aborts early on the first non-lowercase/space byte, so a search controller can reject a key without decrypting the whole message.

---
 rtl/rc4_pkg.sv | 18 +
 rtl/rc4_decrypt_core_byte_check.sv | 11 +
 rtl/rc4_decrypt_core.sv | 227 ++++++++++++++++++++++
 tb/tb_rc4_decrypt_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared constants and the state encoding for the ARC4 decryption engine
// and its plaintext byte checker.
package rc4_pkg;

  localparam int         S_SIZE  = 256;
  localparam logic [7:0] CHAR_A  = 8'h61;
  localparam logic [7:0] CHAR_Z  = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_K_RDI, ST_K_WTI, ST_K_LATI, ST_K_RDJ, ST_K_WTJ, ST_K_LATJ, ST_K_WRJ,
    ST_P_INC, ST_P_RDI, ST_P_WTI, ST_P_LATI, ST_P_RDJ, ST_P_WTJ, ST_P_LATJ,
    ST_P_WRJ, ST_P_RDF, ST_P_WTF, ST_P_OUT
  } rc4_state_e;

endpackage

// File: rtl/rc4_decrypt_core_byte_check.sv
// Plaintext acceptance test: a byte is valid when it is lowercase a..z or space.
module rc4_byte_check
  import rc4_pkg::*;
(
  input  logic [7:0] data_in,
  output logic       valid
);

  assign valid = ((data_in >= CHAR_A) && (data_in <= CHAR_Z)) || (data_in == CHAR_SP);

endmodule

// File: rtl/rc4_decrypt_core.sv
// ARC4 decryption engine: S init, key schedule and keystream/XOR over a message,
// with optional early abort on the first byte outside lowercase/space.
module rc4_decrypt_core
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int MSG_AW    = $clog2(MSG_LEN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   check_en,
  input  logic [KEY_BYTES*8-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic                   ok,
  output logic [MSG_AW-1:0]      fail_idx,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_wren,
  input  logic [7:0]             s_q,
  output logic [MSG_AW-1:0]      e_addr,
  input  logic [7:0]             e_q,
  output logic [MSG_AW-1:0]      d_addr,
  output logic [7:0]             d_wdata,
  output logic                   d_wren,
  output rc4_state_e             dbg_state
);

  localparam int                KIW       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIW-1:0]    KIDX_LAST = KIW'(KEY_BYTES - 1);
  localparam logic [MSG_AW-1:0] K_LAST    = MSG_AW'(MSG_LEN - 1);

  rc4_state_e        state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [MSG_AW-1:0] k_q, k_d, fail_idx_q, fail_idx_d;
  logic [KIW-1:0]    kidx_q, kidx_d;
  logic              chk_q, chk_d, ok_q, ok_d, done_q, done_d;

  logic [KEY_BYTES*8-1:0] key_sh;
  logic [7:0]             key_byte;
  logic [7:0]             out_byte;
  logic                   out_valid;

  // key[0] is the most significant byte, so shift the selected byte to the top.
  assign key_sh   = key << {kidx_q, 3'b000};
  assign key_byte = key_sh[KEY_BYTES*8-1 -: 8];
  assign out_byte = s_q ^ e_q;

  rc4_byte_check u_byte_check (
    .data_in (out_byte),
    .valid   (out_valid)
  );

  // Handshake: start is a level sampled only in IDLE; busy is high from the
  // next cycle until the run ends; done pulses for one cycle with ok/fail_idx
  // already valid, and those stay held until the next accepted start.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    k_d        = k_q;
    kidx_d     = kidx_q;
    chk_d      = chk_q;
    ok_d       = ok_q;
    fail_idx_d = fail_idx_q;
    done_d     = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_wren     = 1'b0;
    d_wdata    = '0;
    d_wren     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          chk_d      = check_en;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          kidx_d     = '0;
          ok_d       = 1'b0;
          fail_idx_d = '0;
          state_d    = ST_INIT;
        end
      end
      ST_INIT: begin
        s_addr  = i_q;
        s_wdata = i_q;
        s_wren  = 1'b1;
        i_d     = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = ST_K_RDI;
      end
      ST_K_RDI: begin
        s_addr  = i_q;
        state_d = ST_K_WTI;
      end
      ST_K_WTI: state_d = ST_K_LATI;
      ST_K_LATI: begin
        si_d    = s_q;
        j_d     = j_q + s_q + key_byte;
        state_d = ST_K_RDJ;
      end
      ST_K_RDJ: begin
        s_addr  = j_q;
        state_d = ST_K_WTJ;
      end
      ST_K_WTJ: state_d = ST_K_LATJ;
      ST_K_LATJ: begin
        sj_d    = s_q;
        s_addr  = i_q;
        s_wdata = s_q;
        s_wren  = 1'b1;
        state_d = ST_K_WRJ;
      end
      ST_K_WRJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        i_d     = i_q + 8'd1;
        kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
        if (i_q == 8'hFF) begin
          j_d     = '0;
          k_d     = '0;
          state_d = ST_P_INC;
        end else begin
          state_d = ST_K_RDI;
        end
      end
      ST_P_INC: begin
        i_d     = i_q + 8'd1;
        state_d = ST_P_RDI;
      end
      ST_P_RDI: begin
        s_addr  = i_q;
        state_d = ST_P_WTI;
      end
      ST_P_WTI: state_d = ST_P_LATI;
      ST_P_LATI: begin
        si_d    = s_q;
        j_d     = j_q + s_q;
        state_d = ST_P_RDJ;
      end
      ST_P_RDJ: begin
        s_addr  = j_q;
        state_d = ST_P_WTJ;
      end
      ST_P_WTJ: state_d = ST_P_LATJ;
      ST_P_LATJ: begin
        sj_d    = s_q;
        s_addr  = i_q;
        s_wdata = s_q;
        s_wren  = 1'b1;
        state_d = ST_P_WRJ;
      end
      ST_P_WRJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        state_d = ST_P_RDF;
      end
      ST_P_RDF: begin
        s_addr  = si_q + sj_q;
        state_d = ST_P_WTF;
      end
      ST_P_WTF: state_d = ST_P_OUT;
      ST_P_OUT: begin
        // The failing byte is still written so the RAM shows what was rejected.
        d_wdata = out_byte;
        d_wren  = 1'b1;
        if (chk_q && !out_valid) begin
          fail_idx_d = k_q;
          ok_d       = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else if (k_q == K_LAST) begin
          ok_d    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_P_INC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      k_q        <= '0;
      kidx_q     <= '0;
      chk_q      <= 1'b0;
      ok_q       <= 1'b0;
      fail_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      kidx_q     <= kidx_d;
      chk_q      <= chk_d;
      ok_q       <= ok_d;
      fail_idx_q <= fail_idx_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ok        = ok_q;
  assign fail_idx  = fail_idx_q;
  assign e_addr    = k_q;
  assign d_addr    = k_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: a 9-byte and an 8-byte message instance, each
// with registered-read S RAM, encrypted ROM and decrypted RAM models.
module tb_rc4_decrypt_core;
  import rc4_pkg::*;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] start = '0;
  logic check_en = 1'b0;
  logic [23:0] key = '0;

  logic [1:0] busy_w, done_w, ok_w, s_wren_w, d_wren_w;
  logic [1:0][7:0] s_addr_w, s_wdata_w, d_wdata_w;
  logic [1:0][AW-1:0] fail_w, d_addr_w;
  logic [7:0] e_rom [2][16];

  int n_checks = 0;
  int n_fail = 0;
  int busy_cnt [2];
  int s_wr_cnt = 0;
  int d_wr_cnt = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];       // {d_addr, d_wdata}
  logic [31:0] exp_done_q[$];  // {ok, 3'b0, fail_idx, 8'b0, latency[15:0]}

  logic [71:0] v1_ct = 72'hBBF316E8D940AF0AD3;
  logic [71:0] v1_pt = "Plaintext";
  logic [63:0] v3_pt = "abc defg";

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int ML  = (g == 0) ? 9 : 8;
    localparam int MAW = $clog2(ML);
    logic [MAW-1:0] fail_n, e_addr_n, d_addr_n;
    logic [7:0] s_q_n, s_pipe, e_q_n, e_pipe;
    logic [7:0] s_mem [256];
    logic [7:0] d_ram [16];
    rc4_state_e state_n;

    rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(ML)) u_dut (
      .clk(clk), .reset(reset), .start(start[g]), .check_en(check_en), .key(key),
      .busy(busy_w[g]), .done(done_w[g]), .ok(ok_w[g]), .fail_idx(fail_n),
      .s_addr(s_addr_w[g]), .s_wdata(s_wdata_w[g]), .s_wren(s_wren_w[g]), .s_q(s_q_n),
      .e_addr(e_addr_n), .e_q(e_q_n),
      .d_addr(d_addr_n), .d_wdata(d_wdata_w[g]), .d_wren(d_wren_w[g]),
      .dbg_state(state_n)
    );

    assign fail_w[g]   = AW'(fail_n);
    assign d_addr_w[g] = AW'(d_addr_n);

    always @(posedge clk) begin
      if (s_wren_w[g]) s_mem[s_addr_w[g]] <= s_wdata_w[g];
      s_pipe <= s_mem[s_addr_w[g]];
      s_q_n  <= s_pipe;
      e_pipe <= e_rom[g][e_addr_n];
      e_q_n  <= e_pipe;
      if (d_wren_w[g]) d_ram[d_addr_n] <= d_wdata_w[g];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every decrypted-RAM write and every done.
  always @(negedge clk) begin
    logic [11:0] e;
    logic [31:0] ed;
    if (!reset) begin
      busy_cnt[0] = 0;
      busy_cnt[1] = 0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (busy_w[g]) busy_cnt[g]++;
        if (s_wren_w[g]) s_wr_cnt++;
        if (d_wren_w[g]) begin
          d_wr_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL d_write: unexpected write addr=%0d data=0x%0h", d_addr_w[g], d_wdata_w[g]);
          end else begin
            e = exp_q.pop_front();
            check("d_write", {20'b0, d_addr_w[g], d_wdata_w[g]}, {20'b0, e});
          end
        end
        if (done_w[g]) begin
          done_cnt++;
          if (exp_done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done: unexpected done pulse, ok=%0d", ok_w[g]);
          end else begin
            ed = exp_done_q.pop_front();
            check("done_ok", 32'(ok_w[g]), 32'(ed[31]));
            if (!ed[31]) check("fail_idx", 32'(fail_w[g]), 32'(ed[27:24]));
            check("done_latency", busy_cnt[g], 32'(ed[15:0]));
          end
          busy_cnt[g] = 0;
        end
      end
    end
  end

  task automatic push_expect(input logic [71:0] pt, input int nbytes, input int nwr,
                             input logic ok_e, input int fidx, input int lat);
    for (int b = 0; b < nwr; b++) exp_q.push_back({4'(b), pt[8*(nbytes-1-b) +: 8]});
    exp_done_q.push_back({ok_e, 3'b0, 4'(fidx), 8'b0, 16'(lat)});
  endtask

  task automatic start_run(input int g, input logic ce, input logic [23:0] kk);
    @(negedge clk);
    key = kk;
    check_en = ce;
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    check_en = 1'b0;
  endtask

  // Waits for one done (bounded), then a quiet window to confirm it was the only one.
  task automatic wait_done(input string name, input int prev);
    int c = 0;
    while (done_cnt == prev && c < 3000) begin
      @(posedge clk);
      c++;
    end
    repeat (20) @(posedge clk);
    check(name, done_cnt - prev, 1);
  endtask

  task automatic check_v1_ram(input string name);
    for (int b = 0; b < 9; b++) check(name, 32'(g_dut[0].d_ram[b]), 32'(v1_pt[8*(8-b) +: 8]));
  endtask

  task automatic gen_rom1(input logic [23:0] kk, input logic [63:0] pt);
    logic [7:0] s [256];
    logic [7:0] ii, jj, t, kb;
    jj = 8'd0;
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      kb = kk[8*(2 - (x % 3)) +: 8];
      jj = jj + s[x] + kb;
      t = s[x]; s[x] = s[jj]; s[jj] = t;
    end
    ii = 8'd0;
    jj = 8'd0;
    for (int b = 0; b < 8; b++) begin
      ii = ii + 8'd1;
      jj = jj + s[ii];
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      t = s[ii] + s[jj];
      e_rom[1][b] = s[t] ^ pt[8*(7-b) +: 8];
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int bad;
    int c;
    for (int b = 0; b < 16; b++) begin
      e_rom[0][b] = (b < 9) ? v1_ct[8*(8-b) +: 8] : 8'h00;
      e_rom[1][b] = 8'h00;
    end
    gen_rom1(24'h000000, v3_pt);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_w[0]), 0);
    check("rst_done", 32'(done_w[0]), 0);
    check("rst_ok", 32'(ok_w[0]), 0);
    check("rst_s_wren", 32'(s_wren_w[0]), 0);
    check("rst_d_wren", 32'(d_wren_w[0]), 0);
    check("rst_s_addr", 32'(s_addr_w[0]), 0);
    check("rst_fail_idx", 32'(fail_w[0]), 0);
    check("rst_state", 32'(g_dut[0].state_n), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;

    // Vector 1 with INIT snapshot
    prev = done_cnt;
    s_wr_cnt = 0;
    d_wr_cnt = 0;
    push_expect(v1_pt, 9, 9, 1'b1, 0, 2147);
    start_run(0, 1'b0, 24'h4B6579);
    repeat (256) @(posedge clk);
    #2;
    check("init_s_wren_count", s_wr_cnt, 256);
    check("init_state", 32'(g_dut[0].state_n), 32'(ST_K_RDI));
    bad = 0;
    for (int x = 0; x < 256; x++) if (g_dut[0].s_mem[x] !== 8'(x)) bad++;
    check("init_s_identity_errors", bad, 0);
    wait_done("v1_done_count", prev);
    check("v1_d_wren_count", d_wr_cnt, 9);
    check_v1_ram("v1_d_ram");

    // Vector 1 with check enabled: 'P' rejected at byte 0
    prev = done_cnt;
    d_wr_cnt = 0;
    push_expect(v1_pt, 9, 1, 1'b0, 0, 2059);
    start_run(0, 1'b1, 24'h4B6579);
    wait_done("v2_done_count", prev);
    check("v2_d_wren_count", d_wr_cnt, 1);

    // Lowercase vector, all-zero key, 8-byte instance
    prev = done_cnt;
    d_wr_cnt = 0;
    push_expect({8'h00, v3_pt}, 8, 8, 1'b1, 0, 2136);
    start_run(1, 1'b1, 24'h000000);
    wait_done("v3_done_count", prev);
    check("v3_d_wren_count", d_wr_cnt, 8);
    for (int b = 0; b < 8; b++) check("v3_d_ram", 32'(g_dut[1].d_ram[b]), 32'(v3_pt[8*(7-b) +: 8]));

    // Reset asserted during PRGA byte 4, at its S write-back cycle
    prev = done_cnt;
    d_wr_cnt = 0;
    push_expect(v1_pt, 9, 9, 1'b1, 0, 2147);
    start_run(0, 1'b0, 24'h4B6579);
    c = 0;
    while (d_wr_cnt < 4 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check("mid_reach_byte4", d_wr_cnt, 4);
    repeat (6) @(posedge clk);
    #2;
    check("mid_pre_busy", 32'(busy_w[0]), 1);
    check("mid_pre_s_wren", 32'(s_wren_w[0]), 1);
    reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy_w[0]), 0);
    check("mid_done", 32'(done_w[0]), 0);
    check("mid_s_wren", 32'(s_wren_w[0]), 0);
    check("mid_d_wren", 32'(d_wren_w[0]), 0);
    check("mid_s_addr", 32'(s_addr_w[0]), 0);
    check("mid_state", 32'(g_dut[0].state_n), 32'(ST_IDLE));
    exp_q.delete();
    exp_done_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("mid_no_done", done_cnt - prev, 0);

    prev = done_cnt;
    d_wr_cnt = 0;
    push_expect(v1_pt, 9, 9, 1'b1, 0, 2147);
    start_run(0, 1'b0, 24'h4B6579);
    wait_done("rerun_done_count", prev);
    check("rerun_d_wren_count", d_wr_cnt, 9);
    check_v1_ram("rerun_d_ram");

    // start (with check_en) pulsed while busy must be ignored
    prev = done_cnt;
    d_wr_cnt = 0;
    push_expect(v1_pt, 9, 9, 1'b1, 0, 2147);
    start_run(0, 1'b0, 24'h4B6579);
    repeat (100) @(posedge clk);
    @(negedge clk);
    start[0] = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check_en = 1'b0;
    wait_done("busy_start_done_count", prev);
    check("busy_start_d_wren_count", d_wr_cnt, 9);

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_done_q_drained", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
